// File: rtl/l15_responder_model.sv
// L1.5-side responder model: acknowledges tile requests, services them from a
// small big-endian word memory and returns OpenPiton-format responses after LATENCY cycles.
module l15_responder_model #(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 4
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         req_val_i,
  input  logic [4:0]   req_rqtype_i,
  input  logic [2:0]   req_size_i,
  input  logic         req_threadid_i,
  input  logic [39:0]  req_address_i,
  input  logic [63:0]  req_data_i,
  output logic         req_ack_o,
  output logic         rtrn_val_o,
  output logic [3:0]   rtrn_type_o,
  output logic         rtrn_error_o,
  output logic         rtrn_threadid_o,
  output logic [255:0] rtrn_data_o,
  input  logic         rtrn_ack_i
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = (LATENCY < 2) ? 1 : $clog2(LATENCY + 1);
  localparam logic [4:0] LOAD_RQ  = 5'b00000;
  localparam logic [4:0] STORE_RQ = 5'b00001;
  localparam logic [4:0] IMISS_RQ = 5'b10000;
  localparam logic [3:0] LOAD_RET  = 4'b0000;
  localparam logic [3:0] IFILL_RET = 4'b0001;
  localparam logic [3:0] ST_ACK    = 4'b0100;
  localparam logic [CW-1:0] CNT_INIT = CW'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, ACK, WAIT, RTRN} state_t;

  state_t         state, next_state;
  logic [CW-1:0]  cnt;
  logic           beat;
  logic [4:0]     rq_type;
  logic [2:0]     rq_size;
  logic           rq_tid;
  logic [2:0]     rq_off;
  logic [AW-1:0]  rq_widx;
  logic [63:0]    rq_data;

  logic [63:0]    mem [DEPTH];
  logic [63:0]    merged;
  logic [7:0]     lane_en;
  logic [3:0]     nbytes;
  logic           store_ok;
  logic [AW-1:0]  rd_base;
  logic [255:0]   rd_data;
  logic           unused_addr;

  assign unused_addr = ^req_address_i[39:3+AW];

  assign nbytes   = 4'd1 << rq_size[1:0];
  assign store_ok = (rq_type == STORE_RQ) && !rq_size[2]
                    && ((rq_off & 3'(nbytes - 4'd1)) == 3'd0);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state <= IDLE;
    else         state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (req_val_i) next_state = ACK;
      ACK:  next_state = (LATENCY == 1) ? RTRN : WAIT;
      WAIT: if (cnt <= CW'(1)) next_state = RTRN;
      RTRN: if (rtrn_ack_i)
              next_state = (rq_type == IMISS_RQ && !beat) ? WAIT : IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Request capture, latency counter and beat tracking for two-beat instruction fills.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt     <= '0;
      beat    <= 1'b0;
      rq_type <= '0;
      rq_size <= '0;
      rq_tid  <= 1'b0;
      rq_off  <= '0;
      rq_widx <= '0;
      rq_data <= '0;
    end else begin
      case (state)
        IDLE: if (req_val_i) begin
          beat    <= 1'b0;
          rq_type <= req_rqtype_i;
          rq_size <= req_size_i;
          rq_tid  <= req_threadid_i;
          rq_off  <= req_address_i[2:0];
          rq_widx <= req_address_i[3 +: AW];
          rq_data <= req_data_i;
        end
        ACK:  cnt <= CNT_INIT;
        WAIT: if (cnt != '0) cnt <= cnt - CW'(1);
        RTRN: if (rtrn_ack_i && rq_type == IMISS_RQ && !beat) begin
          beat <= 1'b1;
          cnt  <= '0;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    merged  = mem[rq_widx];
    lane_en = '0;
    for (int k = 0; k < 8; k++) begin
      lane_en[k] = (4'(k) >= {1'b0, rq_off}) && (4'(k) < ({1'b0, rq_off} + nbytes));
      if (lane_en[k]) merged[63-8*k -: 8] = rq_data[63-8*k -: 8];
    end
  end

  // Memory is deliberately unreset; a legal store lands during the ack cycle.
  always_ff @(posedge clk_i) begin
    if (state == ACK && store_ok) mem[rq_widx] <= merged;
  end

  always_comb begin
    rd_base = (rq_type == IMISS_RQ) ? ((rq_widx & ~AW'(7)) | (beat ? AW'(4) : AW'(0)))
                                    : (rq_widx & ~AW'(3));
    rd_data = '0;
    for (int i = 0; i < 4; i++) rd_data[255-64*i -: 64] = mem[rd_base | AW'(i)];
  end

  always_comb begin
    req_ack_o       = (state == ACK);
    rtrn_val_o      = 1'b0;
    rtrn_type_o     = LOAD_RET;
    rtrn_error_o    = 1'b0;
    rtrn_threadid_o = 1'b0;
    rtrn_data_o     = '0;
    if (state == RTRN) begin
      rtrn_val_o      = 1'b1;
      rtrn_threadid_o = rq_tid;
      case (rq_type)
        LOAD_RQ:  rtrn_data_o = rd_data;
        IMISS_RQ: begin
          rtrn_type_o = IFILL_RET;
          rtrn_data_o = rd_data;
        end
        STORE_RQ: begin
          rtrn_type_o  = ST_ACK;
          rtrn_error_o = !store_ok;
        end
        default:  rtrn_error_o = 1'b1;
      endcase
    end
  end
endmodule

// File: tb/tb_l15_responder_model.sv
// Directed bench for l15_responder_model: a LATENCY=4 instance for load/store
// scenarios and a LATENCY=1 instance for the two-beat instruction fill.
module tb_l15_responder_model;
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         val4 = 1'b0, val1 = 1'b0;
  logic [4:0]   rqtype = '0;
  logic [2:0]   size = '0;
  logic         tid = 1'b0;
  logic [39:0]  addr = '0;
  logic [63:0]  wdata = '0;
  logic         rack4 = 1'b0, rack1 = 1'b0;

  logic         ack_4, rval_4, rerr_4, rtid_4;
  logic [3:0]   rtype_4;
  logic [255:0] rdata_4;
  logic         ack_1, rval_1, rerr_1, rtid_1;
  logic [3:0]   rtype_1;
  logic [255:0] rdata_1;

  int total = 0;
  int bad = 0;

  localparam logic [63:0] W0 = 64'h0011_2233_4455_6677;
  localparam logic [63:0] W1 = 64'h1111_2222_3333_4444;
  localparam logic [63:0] W2 = 64'h5555_6666_7777_8888;
  localparam logic [63:0] W3 = 64'h9999_AAAA_BBBB_CCCC;

  always #5 clk = ~clk;

  l15_responder_model #(.DEPTH(256), .LATENCY(4)) dut (
    .clk_i(clk), .rst_ni(rst_n), .req_val_i(val4), .req_rqtype_i(rqtype),
    .req_size_i(size), .req_threadid_i(tid), .req_address_i(addr), .req_data_i(wdata),
    .req_ack_o(ack_4), .rtrn_val_o(rval_4), .rtrn_type_o(rtype_4), .rtrn_error_o(rerr_4),
    .rtrn_threadid_o(rtid_4), .rtrn_data_o(rdata_4), .rtrn_ack_i(rack4));

  l15_responder_model #(.DEPTH(256), .LATENCY(1)) dut1 (
    .clk_i(clk), .rst_ni(rst_n), .req_val_i(val1), .req_rqtype_i(rqtype),
    .req_size_i(size), .req_threadid_i(tid), .req_address_i(addr), .req_data_i(wdata),
    .req_ack_o(ack_1), .rtrn_val_o(rval_1), .rtrn_type_o(rtype_1), .rtrn_error_o(rerr_1),
    .rtrn_threadid_o(rtid_1), .rtrn_data_o(rdata_1), .rtrn_ack_i(rack1));

  // One single-beat transaction; cycle numbers count edges after val is raised (-1 = never seen).
  task automatic do_req(input bit sel, input logic [4:0] t, input logic [2:0] sz,
                        input logic th, input logic [39:0] a, input logic [63:0] d,
                        output int ack_cyc, output int val_cyc, output logic [3:0] ty,
                        output logic er, output logic otid, output logic [255:0] od);
    int cyc = 0;
    ack_cyc = -1; val_cyc = -1; ty = 'x; er = 1'bx; otid = 1'bx; od = 'x;
    rqtype = t; size = sz; tid = th; addr = a; wdata = d;
    if (sel) val1 = 1'b1; else val4 = 1'b1;
    while (val_cyc < 0 && cyc < 60) begin
      @(posedge clk); #1; cyc++;
      if (ack_cyc < 0 && (sel ? ack_1 : ack_4)) begin
        ack_cyc = cyc; val1 = 1'b0; val4 = 1'b0;
      end
      if (sel ? rval_1 : rval_4) begin
        val_cyc = cyc;
        ty = sel ? rtype_1 : rtype_4; er = sel ? rerr_1 : rerr_4;
        otid = sel ? rtid_1 : rtid_4; od = sel ? rdata_1 : rdata_4;
      end
    end
    val1 = 1'b0; val4 = 1'b0;
    if (val_cyc >= 0) begin
      if (sel) rack1 = 1'b1; else rack4 = 1'b1;
      @(posedge clk); #1;
      rack1 = 1'b0; rack4 = 1'b0;
    end
  endtask

  task automatic test_reset;
    total += 6;
    if (ack_4 !== 1'b0)   begin bad++; $display("[TB] FAIL reset_ack got=%b want=0", ack_4); end
    if (rval_4 !== 1'b0)  begin bad++; $display("[TB] FAIL reset_val got=%b want=0", rval_4); end
    if (rerr_4 !== 1'b0)  begin bad++; $display("[TB] FAIL reset_err got=%b want=0", rerr_4); end
    if (rtype_4 !== 4'h0) begin bad++; $display("[TB] FAIL reset_type got=%h want=0", rtype_4); end
    if (rtid_4 !== 1'b0)  begin bad++; $display("[TB] FAIL reset_tid got=%b want=0", rtid_4); end
    if (rdata_4 !== '0)   begin bad++; $display("[TB] FAIL reset_data got=%h want=0", rdata_4); end
  endtask

  task automatic test_preload;
    int a, v; logic [3:0] ty; logic er, ot; logic [255:0] od;
    logic [63:0] w [3];
    w[0] = W1; w[1] = W2; w[2] = W3;
    for (int i = 0; i < 3; i++) begin
      do_req(1'b0, 5'b00001, 3'd3, 1'b0, 40'h108 + 40'(8*i), w[i], a, v, ty, er, ot, od);
      total += 3;
      if (v - a !== 4) begin bad++; $display("[TB] FAIL preload_lat%0d got=%0d want=4", i, v - a); end
      if (ty !== 4'h4) begin bad++; $display("[TB] FAIL preload_type%0d got=%h want=4", i, ty); end
      if (er !== 1'b0) begin bad++; $display("[TB] FAIL preload_err%0d got=%b want=0", i, er); end
    end
  endtask

  task automatic test_store_load;
    int a, v; logic [3:0] ty; logic er, ot; logic [255:0] od;
    do_req(1'b0, 5'b00001, 3'd3, 1'b1, 40'h100, W0, a, v, ty, er, ot, od);
    total += 6;
    if (a !== 1)      begin bad++; $display("[TB] FAIL st_ack_cycle got=%0d want=1", a); end
    if (v - a !== 4)  begin bad++; $display("[TB] FAIL st_latency got=%0d want=4", v - a); end
    if (ty !== 4'h4)  begin bad++; $display("[TB] FAIL st_type got=%h want=4", ty); end
    if (er !== 1'b0)  begin bad++; $display("[TB] FAIL st_err got=%b want=0", er); end
    if (ot !== 1'b1)  begin bad++; $display("[TB] FAIL st_tid got=%b want=1", ot); end
    if (od !== '0)    begin bad++; $display("[TB] FAIL st_data got=%h want=0", od); end
    do_req(1'b0, 5'b00000, 3'd3, 1'b0, 40'h108, 64'h0, a, v, ty, er, ot, od);
    total += 4;
    if (v - a !== 4)  begin bad++; $display("[TB] FAIL ld_latency got=%0d want=4", v - a); end
    if (ty !== 4'h0)  begin bad++; $display("[TB] FAIL ld_type got=%h want=0", ty); end
    if (er !== 1'b0)  begin bad++; $display("[TB] FAIL ld_err got=%b want=0", er); end
    if (od !== {W0, W1, W2, W3}) begin bad++; $display("[TB] FAIL ld_data got=%h want=%h", od, {W0, W1, W2, W3}); end
  endtask

  task automatic test_partial_store;
    int a, v; logic [3:0] ty; logic er, ot; logic [255:0] od;
    do_req(1'b0, 5'b00001, 3'd0, 1'b0, 40'h103, 64'hAAAA_AAAA_AAAA_AAAA, a, v, ty, er, ot, od);
    do_req(1'b0, 5'b00000, 3'd3, 1'b0, 40'h100, 64'h0, a, v, ty, er, ot, od);
    total += 2;
    if (od[255:192] !== 64'h0011_22AA_4455_6677) begin bad++; $display("[TB] FAIL byte_store got=%h want=001122aa44556677", od[255:192]); end
    if (od[191:0] !== {W1, W2, W3}) begin bad++; $display("[TB] FAIL byte_store_rest got=%h", od[191:0]); end
    do_req(1'b0, 5'b00001, 3'd1, 1'b0, 40'h106, 64'h0123_4567_89AB_CDEF, a, v, ty, er, ot, od);
    total += 1;
    if (er !== 1'b0) begin bad++; $display("[TB] FAIL half_store_err got=%b want=0", er); end
    do_req(1'b0, 5'b00000, 3'd3, 1'b0, 40'h100, 64'h0, a, v, ty, er, ot, od);
    total += 1;
    if (od[255:192] !== 64'h0011_22AA_4455_CDEF) begin bad++; $display("[TB] FAIL half_store got=%h want=001122aa4455cdef", od[255:192]); end
  endtask

  task automatic test_misaligned;
    int a, v; logic [3:0] ty; logic er, ot; logic [255:0] od;
    do_req(1'b0, 5'b00001, 3'd2, 1'b0, 40'h102, 64'hFFFF_FFFF_FFFF_FFFF, a, v, ty, er, ot, od);
    total += 3;
    if (er !== 1'b1)  begin bad++; $display("[TB] FAIL misalign_err got=%b want=1", er); end
    if (ty !== 4'h4)  begin bad++; $display("[TB] FAIL misalign_type got=%h want=4", ty); end
    if (od !== '0)    begin bad++; $display("[TB] FAIL misalign_data got=%h want=0", od); end
    do_req(1'b0, 5'b00001, 3'd4, 1'b0, 40'h100, 64'hFFFF_FFFF_FFFF_FFFF, a, v, ty, er, ot, od);
    total += 1;
    if (er !== 1'b1)  begin bad++; $display("[TB] FAIL size4_err got=%b want=1", er); end
    // Upper address bits alias back onto word 0x100.
    do_req(1'b0, 5'b00000, 3'd3, 1'b0, 40'h900, 64'h0, a, v, ty, er, ot, od);
    total += 1;
    if (od !== {64'h0011_22AA_4455_CDEF, W1, W2, W3}) begin bad++; $display("[TB] FAIL misalign_unchanged got=%h", od); end
  endtask

  task automatic test_imiss;
    int a, v, cyc; logic [3:0] ty; logic er, ot; logic [255:0] od, exp0, exp1;
    for (int i = 0; i < 8; i++) begin
      do_req(1'b1, 5'b00001, 3'd3, 1'b0, 40'h1C0 + 40'(8*i), 64'hF0F0_0000_0000_0000 + 64'(i), a, v, ty, er, ot, od);
      if (i < 4) exp0[255-64*i -: 64] = 64'hF0F0_0000_0000_0000 + 64'(i);
      else       exp1[255-64*(i-4) -: 64] = 64'hF0F0_0000_0000_0000 + 64'(i);
    end
    rqtype = 5'b10000; size = 3'd3; tid = 1'b1; addr = 40'h1C4; wdata = '0; val1 = 1'b1;
    a = -1; v = -1; cyc = 0;
    while (v < 0 && cyc < 40) begin
      @(posedge clk); #1; cyc++;
      if (a < 0 && ack_1) begin a = cyc; val1 = 1'b0; end
      if (rval_1) v = cyc;
    end
    val1 = 1'b0;
    total += 4;
    if (v - a !== 1)   begin bad++; $display("[TB] FAIL if_latency got=%0d want=1", v - a); end
    if (rtype_1 !== 4'h1) begin bad++; $display("[TB] FAIL if_type0 got=%h want=1", rtype_1); end
    if (rtid_1 !== 1'b1)  begin bad++; $display("[TB] FAIL if_tid0 got=%b want=1", rtid_1); end
    if (rdata_1 !== exp0) begin bad++; $display("[TB] FAIL if_beat0 got=%h want=%h", rdata_1, exp0); end
    for (int s = 0; s < 3; s++) begin
      @(posedge clk); #1;
      total += 1;
      if (rval_1 !== 1'b1 || rdata_1 !== exp0) begin bad++; $display("[TB] FAIL if_hold%0d val=%b data=%h", s, rval_1, rdata_1); end
    end
    rack1 = 1'b1; @(posedge clk); #1; rack1 = 1'b0;
    total += 1;
    if (rval_1 !== 1'b0) begin bad++; $display("[TB] FAIL if_gap got=%b want=0", rval_1); end
    @(posedge clk); #1;
    total += 5;
    if (rval_1 !== 1'b1)  begin bad++; $display("[TB] FAIL if_val1 got=%b want=1", rval_1); end
    if (rtype_1 !== 4'h1) begin bad++; $display("[TB] FAIL if_type1 got=%h want=1", rtype_1); end
    if (rtid_1 !== 1'b1)  begin bad++; $display("[TB] FAIL if_tid1 got=%b want=1", rtid_1); end
    if (rerr_1 !== 1'b0)  begin bad++; $display("[TB] FAIL if_err1 got=%b want=0", rerr_1); end
    if (rdata_1 !== exp1) begin bad++; $display("[TB] FAIL if_beat1 got=%h want=%h", rdata_1, exp1); end
    rack1 = 1'b1; @(posedge clk); #1; rack1 = 1'b0;
    total += 1;
    if (rval_1 !== 1'b0) begin bad++; $display("[TB] FAIL if_done got=%b want=0", rval_1); end
  endtask

  task automatic test_back_to_back;
    int acks = 0, cyc = 0; bit seen = 0;
    logic [3:0] ty; logic er; logic [255:0] od;
    rqtype = 5'b00100; size = 3'd3; tid = 1'b0; addr = 40'h100; wdata = '0; val4 = 1'b1;
    while (!seen && cyc < 40) begin
      @(posedge clk); #1; cyc++;
      if (ack_4) acks++;
      if (rval_4) begin seen = 1; ty = rtype_4; er = rerr_4; od = rdata_4; end
    end
    total += 4;
    if (acks !== 1)   begin bad++; $display("[TB] FAIL held_acks got=%0d want=1", acks); end
    if (ty !== 4'h0)  begin bad++; $display("[TB] FAIL unsup_type got=%h want=0", ty); end
    if (er !== 1'b1)  begin bad++; $display("[TB] FAIL unsup_err got=%b want=1", er); end
    if (od !== '0)    begin bad++; $display("[TB] FAIL unsup_data got=%h want=0", od); end
    rack4 = 1'b1; @(posedge clk); #1; rack4 = 1'b0; val4 = 1'b0;
    @(posedge clk); #1;
    total += 1;
    if (ack_4 !== 1'b0 || rval_4 !== 1'b0) begin bad++; $display("[TB] FAIL unsup_idle ack=%b val=%b want 0/0", ack_4, rval_4); end
  endtask

  task automatic test_reset_mid;
    int a, v, cyc = 0; logic [3:0] ty; logic er, ot; logic [255:0] od;
    rqtype = 5'b00000; size = 3'd3; tid = 1'b0; addr = 40'h100; val4 = 1'b1;
    while (!rval_4 && cyc < 40) begin
      @(posedge clk); #1; cyc++;
      if (ack_4) val4 = 1'b0;
    end
    val4 = 1'b0;
    total += 1;
    if (rval_4 !== 1'b1) begin bad++; $display("[TB] FAIL rst_pre_val got=%b want=1", rval_4); end
    #2 rst_n = 1'b0;
    #1;
    total += 1;
    if (rval_4 !== 1'b0) begin bad++; $display("[TB] FAIL rst_async_val got=%b want=0", rval_4); end
    @(posedge clk); @(posedge clk); #1;
    total += 1;
    if (ack_4 !== 1'b0 || rval_4 !== 1'b0) begin bad++; $display("[TB] FAIL rst_hold ack=%b val=%b", ack_4, rval_4); end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    do_req(1'b0, 5'b00000, 3'd3, 1'b0, 40'h118, 64'h0, a, v, ty, er, ot, od);
    total += 3;
    if (a !== 1)     begin bad++; $display("[TB] FAIL rst_next_ack got=%0d want=1", a); end
    if (v - a !== 4) begin bad++; $display("[TB] FAIL rst_next_lat got=%0d want=4", v - a); end
    if (od !== {64'h0011_22AA_4455_CDEF, W1, W2, W3}) begin bad++; $display("[TB] FAIL rst_next_data got=%h", od); end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    test_reset;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    test_preload;
    test_store_load;
    test_partial_store;
    test_misaligned;
    test_imiss;
    test_back_to_back;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/l15_responder_model.md
Name: l15_responder_model

Overview:
- Synthesizable L1.5-side responder for standalone tile bring-up and unit benches. Sits where OpenPiton's L1.5 would sit, facing the tile's HPDC/L1.5 adapter.
- Accepts L1.5 requests (load, store, instruction miss) from the tile and services them from a small internal word memory.
- Returns OpenPiton-format responses with configurable latency.

Parameters:
- DEPTH, 256, number of 64-bit memory words (power of 2, ≥8).
- LATENCY, 4, cycles from the request-ack cycle to the first return valid (≥1).

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- req_val_i  in  1  request valid; held by the tile until acked
- req_rqtype_i  in  5  00000 LOAD_RQ, 00001 STORE_RQ, 10000 IMISS_RQ
- req_size_i  in  3  0=1B 1=2B 2=4B 3=8B (others: line)
- req_threadid_i  in  1  thread id, echoed on return
- req_address_i  in  40  physical byte address
- req_data_i  in  64  store data, big-endian byte lanes
- req_ack_o  out  1  one-cycle request-header acknowledge
- rtrn_val_o  out  1  return valid
- rtrn_type_o  out  4  0000 LOAD_RET, 0001 IFILL_RET, 0100 ST_ACK
- rtrn_error_o  out  1  request unsupported or misaligned
- rtrn_threadid_o  out  1  echoed thread id
- rtrn_data_o  out  256  {data_0,data_1,data_2,data_3}, data_0 in bits [255:192]
- rtrn_ack_i  in  1  tile consumes the current return beat

Behaviour:
- Reset (async, rst_ni low): FSM to IDLE; req_ack_o, rtrn_val_o, rtrn_error_o = 0; rtrn_type_o, rtrn_threadid_o, rtrn_data_o = 0; latency counter = 0. Memory is not reset (contents retained; power-up undefined). Reset mid-operation abandons the transaction with no partial return.
- Memory: word index = req_address_i[3+:log2(DEPTH)]. Upper address bits are ignored, so addresses alias modulo DEPTH*8. Byte at offset k of a word lives in bits [63-8k -: 8] (big-endian).
- FSM states: IDLE, ACK, WAIT, RTRN.
- IDLE: if req_val_i, capture all request fields and go to ACK.
- ACK: assert req_ack_o for exactly one cycle. For a legal store, perform the memory write this cycle. Load counter to LATENCY-1, go to WAIT.
- WAIT: decrement the counter; at 0 go to RTRN. First rtrn_val_o is therefore exactly LATENCY cycles after the ack cycle.
- RTRN: hold rtrn_val_o and all rtrn_* stable until rtrn_ack_i=1. A beat completes on val & ack.
  - LOAD_RQ/IMISS_RQ beat 0 with a second beat pending: go to WAIT with counter 0 (one-cycle gap), then return beat 1.
  - Last beat completes: go to IDLE. req_ack_o is never asserted outside ACK, so a new request is not accepted while busy.
- LOAD_RQ: one beat, LOAD_RET. Data = the 4 words of the 32B-aligned block containing the address (address[4:3] ignored); word at offset 0 goes in data_0.
- IMISS_RQ: two beats, IFILL_RET, for the 64B-aligned block. Beat 0 carries bytes 0–31, beat 1 carries bytes 32–63.
- STORE_RQ: one beat, ST_ACK, rtrn_data_o = 0.
  - Legal when size ≤3 and address[2:0] is aligned to 2^size.
  - Write only the addressed byte lanes, taken from the same lanes of req_data_i.
  - Misaligned or size >3: no write, rtrn_error_o = 1.
- Any other rqtype: acked normally; one LOAD_RET beat, rtrn_error_o = 1, data 0.
- rtrn_threadid_o always equals the captured threadid.
- Store-then-load to the same word returns the new data (the write completes before any later capture).

Test Plan:
- Reset mid-RTRN (rtrn_ack_i held 0): rtrn_val_o drops asynchronously with rst_ni. After release, state is IDLE and the next request is acked normally.
- STORE_RQ size=3 addr 0x100 data 0x0011223344556677, then LOAD_RQ addr 0x108 (defaults) → ack 1 cycle after val; ST_ACK val exactly 4 cycles after ack; LOAD_RET data_0 = 0x0011223344556677, data_1..3 per prior contents, error 0.
- STORE_RQ size=0 addr 0x103 data 0xAAAA...AA, then load 0x100 → only byte 3 changes: data_0 = 0x001122AA44556677.
- STORE_RQ size=2 addr 0x102 → ST_ACK with error=1; subsequent load shows word 0x100 unchanged.
- IMISS_RQ addr 0x1C4, threadid=1, LATENCY=1, rtrn_ack_i held 0 for 3 cycles → beat 0 (bytes 0x1C0–0x1DF) held stable for 3 cycles; one-cycle gap; beat 1 (0x1E0–0x1FF); both IFILL_RET, threadid 1.
- req_val_i held high through a full load transaction, rqtype=00100 → exactly one ack per transaction; unsupported request returns LOAD_RET, error 1, data 0.
